ps2_note_decoder: RTL and testbench
===================================

Name: ps2_note_decoder

Overview:
- Producer side of the synth's note interface. Consumes the PS/2 Set-2 scan-code byte stream delivered by the PS/2 receiver.
- Decodes make and break sequences for 26 piano-layout keys and tracks which keys are held.
- Drives key_pressed and current_note_on_key into the sustain and voice logic.
- Note codes: 0 = no note, 1..25 = chromatic C3..C5.

Parameters:
- NOTE_W, 5, width of the note code. Fixed at 5; other values are unsupported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_byte  in  8  received scan-code byte; valid only when ps2_byte_valid=1
- ps2_byte_valid  in  1  one-cycle strobe per received byte
- key_pressed  out  1  1 while at least one mapped key is held
- current_note_on_key  out  5  note of the active key; 0 when none held
- note_change  out  1  one-cycle pulse when key_pressed or current_note_on_key changes
- held_mask  out  26  per-slot held flags, for debug and LEDs

Behaviour:
- Reset: clock is the system clock; reset is synchronous and active-high. All registers clear: prefix state IDLE, held_mask=0, current_note_on_key=0, key_pressed=0, note_change=0. Reset wins over a coincident ps2_byte_valid.
- Key slots (Set-2 make codes):
  - Bottom row, slots 0..12, notes 1..13: Z 1A, S 1B, X 22, D 23, C 21, V 2A, G 34, B 32, H 33, N 31, J 3B, M 3A, comma 41.
  - Top row, slots 13..25, notes 13..25: Q 15, 2 1E, W 1D, 3 26, E 24, R 2D, 5 2E, T 2C, 6 36, Y 35, 7 3D, U 3C, I 43.
  - Slots 12 and 13 both give note 13 and are tracked independently.
- Prefix FSM. It advances only on a cycle with ps2_byte_valid=1.
  - IDLE: E0 -> EXT; F0 -> BRK; mapped code -> make event, stay IDLE; any other byte is ignored, stay IDLE.
  - BRK: F0 -> BRK. Any other byte -> release event if mapped, otherwise ignored; go to IDLE. An E0 received in BRK is consumed as an unmapped break.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; any other byte -> IDLE, ignored.
  - EXT_BRK: F0 -> EXT_BRK; any other byte -> IDLE, ignored.
  - Extended keys never affect the note state.
  - E1 pause sequences, AA, FA, FE, 00 and FF pass through the same rules and decode to nothing.
- Make event, slot k:
  - If held_mask[k] is already 1 (typematic repeat), no change and no pulse.
  - Otherwise set held_mask[k]. current_note_on_key becomes note(k) (last-note priority).
- Release event, slot k:
  - If held_mask[k]=0, ignore.
  - Otherwise clear held_mask[k].
  - If note(k) equals current_note_on_key and no other held slot maps to that note, current_note_on_key falls back to the note of the highest-numbered remaining held slot, or 0 if none is held.
  - Otherwise current_note_on_key is unchanged.
- key_pressed is registered and equals |held_mask after the update, so it is never inconsistent with current_note_on_key. key_pressed=0 if and only if current_note_on_key=0.
- Latency: all outputs update on the clock edge that samples ps2_byte_valid, so they are visible one cycle after the strobe.
- note_change is high for exactly that one cycle when either output differs from its previous value; otherwise 0.
- Back-to-back strobes on consecutive cycles are fully supported; there is no stall and no backpressure.
- If reset occurs mid-sequence (for example after F0), the pending prefix is discarded. The next byte is decoded from IDLE.

Test Plan:
1. Reset, then bytes 1A, F0, 1A -> after 1A: key_pressed=1, note=1, note_change pulse. After F0: no change. After 1A: key_pressed=0, note=0, pulse.
2. Press 1A, then 15, then release 15 (F0 15) -> note 1, then 13, then falls back to 1. key_pressed stays 1 throughout; three pulses total.
3. Typematic: 1A sent five times back-to-back -> note=1 after the first byte. note_change pulses exactly once and held_mask=bit0 only.
4. Extended and junk: E0 1A, E0 F0 1A, AA, FA, F0 77 -> no output change, no pulses, held_mask=0, FSM ends in IDLE.
5. Duplicate note: press 41 and 15 (both note 13), release 41 -> note stays 13 with no pulse. Release 15 -> note=0, key_pressed=0, pulse.
6. Press 1A, send F0, assert reset for one cycle, then send 1A -> note=1 (treated as a make, not a break). Separately, ps2_byte_valid coincident with reset -> byte is dropped and outputs stay 0.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// PS/2 Set-2 make/break decoder for 26 piano keys with last-note priority.
// Outputs register on the edge that samples ps2_byte_valid; never stalls, so a byte can arrive every cycle.
module ps2_note_decoder #(
  parameter int NOTE_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ps2_byte,
  input  logic              ps2_byte_valid,
  output logic              key_pressed,
  output logic [NOTE_W-1:0] current_note_on_key,
  output logic              note_change,
  output logic [25:0]       held_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  state_t              r_state;
  logic [25:0]         r_held;
  logic [NOTE_W-1:0]   r_note;
  logic                r_pressed;
  logic                r_change;

  state_t              w_state_nxt;
  logic                w_hit;
  logic [4:0]          w_slot;
  logic [NOTE_W-1:0]   w_slot_note;
  logic [25:0]         w_held_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic [NOTE_W-1:0]   w_fallback;
  logic                w_dup;

  // {hit, slot} for the 26 mapped make codes.
  function automatic logic [5:0] lookup(input logic [7:0] b);
    logic [5:0] r;
    case (b)
      8'h1A: r = {1'b1, 5'd0};
      8'h1B: r = {1'b1, 5'd1};
      8'h22: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};
      8'h21: r = {1'b1, 5'd4};
      8'h2A: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};
      8'h32: r = {1'b1, 5'd7};
      8'h33: r = {1'b1, 5'd8};
      8'h31: r = {1'b1, 5'd9};
      8'h3B: r = {1'b1, 5'd10};
      8'h3A: r = {1'b1, 5'd11};
      8'h41: r = {1'b1, 5'd12};
      8'h15: r = {1'b1, 5'd13};
      8'h1E: r = {1'b1, 5'd14};
      8'h1D: r = {1'b1, 5'd15};
      8'h26: r = {1'b1, 5'd16};
      8'h24: r = {1'b1, 5'd17};
      8'h2D: r = {1'b1, 5'd18};
      8'h2E: r = {1'b1, 5'd19};
      8'h2C: r = {1'b1, 5'd20};
      8'h36: r = {1'b1, 5'd21};
      8'h35: r = {1'b1, 5'd22};
      8'h3D: r = {1'b1, 5'd23};
      8'h3C: r = {1'b1, 5'd24};
      8'h43: r = {1'b1, 5'd25};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Rows overlap on note 13: slot 12 (comma) and slot 13 (Q).
  function automatic logic [NOTE_W-1:0] slot_note(input logic [4:0] s);
    return (s < 5'd13) ? s + 5'd1 : s;
  endfunction

  always_comb begin
    {w_hit, w_slot} = lookup(ps2_byte);
    w_slot_note     = slot_note(w_slot);
    w_held_nxt      = r_held;
    w_note_nxt      = r_note;
    w_fallback      = '0;
    w_dup           = 1'b0;
    w_state_nxt     = r_state;

    case (r_state)
      S_IDLE: begin
        if (ps2_byte == 8'hE0)      w_state_nxt = S_EXT;
        else if (ps2_byte == 8'hF0) w_state_nxt = S_BRK;
        else if (w_hit && !r_held[w_slot]) begin
          w_held_nxt[w_slot] = 1'b1;
          w_note_nxt         = w_slot_note;
        end
      end
      S_BRK: begin
        if (ps2_byte != 8'hF0) begin
          w_state_nxt = S_IDLE;
          if (w_hit && r_held[w_slot]) begin
            w_held_nxt[w_slot] = 1'b0;
            for (int i = 0; i < 26; i++) begin
              if (w_held_nxt[i]) begin
                if (slot_note(5'(i)) == w_slot_note) w_dup = 1'b1;
                w_fallback = slot_note(5'(i));
              end
            end
            if (w_slot_note == r_note && !w_dup) w_note_nxt = w_fallback;
          end
        end
      end
      S_EXT: begin
        if (ps2_byte == 8'hF0)      w_state_nxt = S_EXT_BRK;
        else if (ps2_byte != 8'hE0) w_state_nxt = S_IDLE;
      end
      default: begin
        if (ps2_byte != 8'hF0) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_held    <= '0;
      r_note    <= '0;
      r_pressed <= 1'b0;
      r_change  <= 1'b0;
    end else if (ps2_byte_valid) begin
      r_state   <= w_state_nxt;
      r_held    <= w_held_nxt;
      r_note    <= w_note_nxt;
      r_pressed <= |w_held_nxt;
      r_change  <= ((|w_held_nxt) != r_pressed) || (w_note_nxt != r_note);
    end else begin
      r_change  <= 1'b0;
    end
  end

  assign key_pressed         = r_pressed;
  assign current_note_on_key = r_note;
  assign note_change         = r_change;
  assign held_mask           = r_held;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: keyboard-level model compared every cycle, plus directed literal checks.
module tb_ps2_note_decoder;

  logic        clock;
  logic        reset;
  logic [7:0]  ps2_byte;
  logic        ps2_byte_valid;
  logic        key_pressed;
  logic [4:0]  current_note_on_key;
  logic        note_change;
  logic [25:0] held_mask;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit started = 0;

  ps2_note_decoder #(.NOTE_W(5)) dut (
    .clock               (clock),
    .reset               (reset),
    .ps2_byte            (ps2_byte),
    .ps2_byte_valid      (ps2_byte_valid),
    .key_pressed         (key_pressed),
    .current_note_on_key (current_note_on_key),
    .note_change         (note_change),
    .held_mask           (held_mask)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Keyboard layout: bottom row Z..comma then top row Q..I, in slot order.
  logic [7:0] codes [26] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33,
                             8'h31, 8'h3B, 8'h3A, 8'h41, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24,
                             8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43};

  function automatic int find(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic int note_of(input int k);
    return (k <= 12) ? k + 1 : k;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  bit m_held [26];
  int m_note = 0;
  bit m_pressed = 0;
  bit m_change = 0;
  bit m_ext = 0;
  bit m_brk = 0;

  initial begin : model
    int k;
    bit old_p;
    int old_n;
    bit dup;
    logic [7:0] b;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int j = 0; j < 26; j++) m_held[j] = 0;
        m_note = 0; m_pressed = 0; m_change = 0; m_ext = 0; m_brk = 0;
      end else if (ps2_byte_valid) begin
        old_p = m_pressed;
        old_n = m_note;
        b = ps2_byte;
        if (m_ext) begin
          if (m_brk) begin
            if (b != 8'hF0) begin m_ext = 0; m_brk = 0; end
          end else if (b == 8'hF0) m_brk = 1;
          else if (b != 8'hE0) m_ext = 0;
        end else if (m_brk) begin
          if (b != 8'hF0) begin
            m_brk = 0;
            k = find(b);
            if (k >= 0 && m_held[k]) begin
              m_held[k] = 0;
              if (note_of(k) == m_note) begin
                dup = 0;
                for (int j = 0; j < 26; j++) if (m_held[j] && note_of(j) == m_note) dup = 1;
                if (!dup) begin
                  m_note = 0;
                  for (int j = 0; j < 26; j++) if (m_held[j]) m_note = note_of(j);
                end
              end
            end
          end
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
          k = find(b);
          if (k >= 0 && !m_held[k]) begin
            m_held[k] = 1;
            m_note = note_of(k);
          end
        end
        m_pressed = 0;
        for (int j = 0; j < 26; j++) if (m_held[j]) m_pressed = 1;
        m_change = (m_pressed != old_p) || (m_note != old_n);
      end else begin
        m_change = 0;
      end
    end
  end

  initial begin : compare
    int mask;
    forever begin
      @(negedge clock);
      if (started) begin
        mask = 0;
        for (int j = 0; j < 26; j++) if (m_held[j]) mask |= (1 << j);
        chk("cyc_key_pressed", int'(key_pressed), int'(m_pressed));
        chk("cyc_note", int'(current_note_on_key), m_note);
        chk("cyc_note_change", int'(note_change), int'(m_change));
        chk("cyc_held_mask", int'(held_mask), mask);
        if (note_change) pulses++;
      end
    end
  end

  // Inputs change 1ns after the falling edge; outputs are read there too.
  task automatic send(input logic [7:0] b);
    ps2_byte = b;
    ps2_byte_valid = 1;
    @(negedge clock); #1;
    ps2_byte_valid = 0;
  endtask

  task automatic idle();
    @(negedge clock); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int base;

  initial begin : stim
    reset = 1; ps2_byte = 0; ps2_byte_valid = 0;
    @(negedge clock); @(negedge clock); #1;
    started = 1;
    reset = 0;
    chk("rst_pressed", int'(key_pressed), 0);
    chk("rst_note", int'(current_note_on_key), 0);
    chk("rst_change", int'(note_change), 0);
    chk("rst_mask", int'(held_mask), 0);

    // 1: simple make/break
    base = pulses;
    send(8'h1A);
    chk("t1_make_pressed", int'(key_pressed), 1);
    chk("t1_make_note", int'(current_note_on_key), 1);
    chk("t1_make_pulse", int'(note_change), 1);
    send(8'hF0);
    chk("t1_f0_note", int'(current_note_on_key), 1);
    chk("t1_f0_pulse", int'(note_change), 0);
    send(8'h1A);
    chk("t1_brk_pressed", int'(key_pressed), 0);
    chk("t1_brk_note", int'(current_note_on_key), 0);
    chk("t1_brk_pulse", int'(note_change), 1);
    idle();
    chk("t1_pulses", pulses - base, 2);

    // 2: last-note priority and fallback
    base = pulses;
    send(8'h1A);
    send(8'h15);
    chk("t2_note13", int'(current_note_on_key), 13);
    send(8'hF0); send(8'h15);
    chk("t2_fallback", int'(current_note_on_key), 1);
    chk("t2_pressed", int'(key_pressed), 1);
    idle();
    chk("t2_pulses", pulses - base, 3);
    send(8'hF0); send(8'h1A);
    chk("t2_clear", int'(current_note_on_key), 0);

    // 3: typematic back-to-back
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      ps2_byte = 8'h1A; ps2_byte_valid = 1;
      @(negedge clock); #1;
    end
    ps2_byte_valid = 0;
    idle();
    chk("t3_note", int'(current_note_on_key), 1);
    chk("t3_mask", int'(held_mask), 1);
    chk("t3_pulses", pulses - base, 1);
    send(8'hF0); send(8'h1A);

    // 4: extended and junk
    idle();
    base = pulses;
    send(8'hE0); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h1A);
    send(8'hAA); send(8'hFA);
    send(8'hF0); send(8'h77);
    idle();
    chk("t4_mask", int'(held_mask), 0);
    chk("t4_note", int'(current_note_on_key), 0);
    chk("t4_pulses", pulses - base, 0);
    send(8'h1A);
    chk("t4_idle_make", int'(current_note_on_key), 1);
    send(8'hF0); send(8'h1A);

    // 5: duplicate note 13 on comma and Q
    send(8'h41); send(8'h15);
    chk("t5_note", int'(current_note_on_key), 13);
    idle();
    base = pulses;
    send(8'hF0); send(8'h41);
    chk("t5_dup_note", int'(current_note_on_key), 13);
    chk("t5_dup_pulse", int'(note_change), 0);
    send(8'hF0); send(8'h15);
    chk("t5_last_note", int'(current_note_on_key), 0);
    chk("t5_last_pressed", int'(key_pressed), 0);
    chk("t5_last_pulse", int'(note_change), 1);
    idle();
    chk("t5_pulses", pulses - base, 1);

    // Fallback picks the highest remaining slot; releasing a non-current key keeps the note
    send(8'h1A); send(8'h22); send(8'h15);
    send(8'hF0); send(8'h15);
    chk("fb_highest", int'(current_note_on_key), 3);
    send(8'hF0); send(8'h1A);
    chk("fb_noncurrent", int'(current_note_on_key), 3);
    chk("fb_mask", int'(held_mask), 32'h4);
    send(8'hF0); send(8'h22);
    chk("fb_empty", int'(current_note_on_key), 0);

    // E0 after F0 is an unmapped break, leaving the decoder in IDLE
    send(8'hF0); send(8'hE0); send(8'h1A);
    chk("brk_e0_make", int'(current_note_on_key), 1);
    send(8'hF0); send(8'h1A);

    // 6: reset mid-sequence discards the prefix
    send(8'h1A); send(8'hF0);
    reset = 1; idle(); reset = 0;
    chk("t6_rst_note", int'(current_note_on_key), 0);
    send(8'h1A);
    chk("t6_make_note", int'(current_note_on_key), 1);
    chk("t6_make_mask", int'(held_mask), 1);
    reset = 1; idle();
    ps2_byte = 8'h15; ps2_byte_valid = 1;
    @(negedge clock); #1;
    reset = 0; ps2_byte_valid = 0;
    chk("t6_coinc_note", int'(current_note_on_key), 0);
    chk("t6_coinc_pressed", int'(key_pressed), 0);
    chk("t6_coinc_mask", int'(held_mask), 0);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
